// File: rtl/onehot_decoder_skid.sv
// ---------------------------------------------------------------------------------------------
// onehot_decoder_skid
//   Registered binary-to-one-hot decoder with valid/ready on both sides and a two-entry
//   (output + skid) buffer. It sustains one beat per cycle with a fully registered output.
//
// Optional feature macro: ONEHOT_DECODER_RANGE_CHECK_EN
//   defined   : m_error flags indices >= WIDTH; err_count saturates at 255.
//   undefined : m_error and err_count are tied to 0. Out-of-range indices still decode
//               to an all-zero m_unencoded.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   s_encoded    in   [ENC_WIDTH] index to decode
//   s_valid      in   input beat valid
//   s_ready      out  input beat accepted on s_valid && s_ready (registered)
//   m_unencoded  out  [WIDTH] one-hot decode of the held index
//   m_encoded    out  [ENC_WIDTH] held index, aligned with m_unencoded
//   m_error      out  held index >= WIDTH (qualified by m_valid)
//   m_valid      out  output beat valid
//   m_ready      in   downstream accepts on m_valid && m_ready
//   err_count    out  [8] saturating count of accepted out-of-range beats
// ---------------------------------------------------------------------------------------------
module onehot_decoder_skid #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ENC_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENC_WIDTH-1:0] s_encoded,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     m_unencoded,
  output logic [ENC_WIDTH-1:0] m_encoded,
  output logic                 m_error,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [7:0]           err_count
);

  // Output stage
  logic [ENC_WIDTH-1:0] r_out_idx;
  logic [WIDTH-1:0]     r_out_oh;
  logic                 r_out_err;
  logic                 r_out_valid;

  // Skid stage
  logic [ENC_WIDTH-1:0] r_skid_idx;
  logic [WIDTH-1:0]     r_skid_oh;
  logic                 r_skid_err;
  logic                 r_skid_valid;

  logic                 r_s_ready;

  logic [WIDTH-1:0]     w_in_oh;
  logic                 w_in_err;
  logic                 w_accept;
  logic                 w_out_free;

  assign w_accept   = s_valid && r_s_ready;
  assign w_out_free = !r_out_valid || m_ready;

  // Decode on the input side so both storage stages hold the finished result.
  always_comb begin
    w_in_oh = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s_encoded == ENC_WIDTH'(i)) begin
        w_in_oh[i] = 1'b1;
      end
    end
  end

`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
  // A power-of-two WIDTH covers every encodable index, so no error is possible.
  if (WIDTH == (32'd1 << ENC_WIDTH)) begin : g_err_pow2
    assign w_in_err = 1'b0;
  end else begin : g_err_range
    assign w_in_err = (32'(s_encoded) >= WIDTH);
  end

  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 8'd0;
    end else if (w_accept && w_in_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign w_in_err  = 1'b0;
  assign err_count = 8'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_idx    <= '0;
      r_out_oh     <= '0;
      r_out_err    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_idx   <= '0;
      r_skid_oh    <= '0;
      r_skid_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      // Default keeps s_ready tracking skid occupancy; first edge after reset raises it.
      r_s_ready <= !r_skid_valid;
      if (w_out_free) begin
        if (r_skid_valid) begin
          // Skid drains into out; no input can be accepted this cycle (s_ready is 0).
          r_out_idx    <= r_skid_idx;
          r_out_oh     <= r_skid_oh;
          r_out_err    <= r_skid_err;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
          r_s_ready    <= 1'b1;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) begin
            r_out_idx <= s_encoded;
            r_out_oh  <= w_in_oh;
            r_out_err <= w_in_err;
          end
        end
      end else if (w_accept) begin
        // Out is stalled: park the beat and close the input on the next cycle.
        r_skid_idx   <= s_encoded;
        r_skid_oh    <= w_in_oh;
        r_skid_err   <= w_in_err;
        r_skid_valid <= 1'b1;
        r_s_ready    <= 1'b0;
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign m_valid     = r_out_valid;
  assign m_encoded   = r_out_idx;
  assign m_unencoded = r_out_oh;
  assign m_error     = r_out_err;

endmodule

// File: tb/tb_onehot_decoder_skid.sv
// Scoreboard bench: accepted beats are queued at the input handshake; a negedge monitor
// compares every presented output beat, s_ready, m_valid and err_count against the queue.
module tb_onehot_decoder_skid;

  localparam int unsigned W  = 5;
  localparam int unsigned EW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [EW-1:0] s_encoded;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  m_unencoded;
  logic [EW-1:0] m_encoded;
  logic          m_error;
  logic          m_valid;
  logic          m_ready;
  logic [7:0]    err_count;

  onehot_decoder_skid #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_encoded   (s_encoded),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_unencoded (m_unencoded),
    .m_encoded   (m_encoded),
    .m_error     (m_error),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned q[$];
  int          exp_cnt   = 0;
  int          beats_in  = 0;
  int          beats_out = 0;
  logic        hold_prev = 1'b0;
  logic [EW-1:0] prev_idx;
  logic [W-1:0]  prev_oh;
  logic          prev_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_onehot(input int unsigned idx);
    logic [W-1:0] one;
    one = 1;
    return (idx < W) ? (one << idx) : '0;
  endfunction

  function automatic logic ref_err(input int unsigned idx);
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    return idx >= W;
`else
    return (idx >= W) && 1'b0;
`endif
  endfunction

  // Input side of the scoreboard: record every accepted beat.
  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready) begin
      q.push_back(int'(s_encoded));
      beats_in++;
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
      if (s_encoded >= W && exp_cnt < 255) exp_cnt++;
`endif
    end
  end

  // Output monitor. The queue holds exactly the beats resident in the DUT.
  always @(negedge clk) begin
    if (rst_n) begin
      int unsigned idx;
      check("s_ready_occupancy", s_ready, q.size() < 2);
      check("m_valid_occupancy", m_valid, q.size() != 0);
      if (hold_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_encoded", m_encoded, prev_idx);
        check("hold_unencoded", m_unencoded, prev_oh);
        check("hold_error", m_error, prev_err);
      end
      if (m_valid && q.size() != 0) begin
        idx = q[0];
        check("m_encoded", m_encoded, idx);
        check("m_unencoded", m_unencoded, ref_onehot(idx));
        check("m_error", m_error, ref_err(idx));
        if (!m_error && m_encoded < W) check("onehot_consistent", m_unencoded, ref_onehot(m_encoded));
        if (m_ready) begin
          void'(q.pop_front());
          beats_out++;
        end
      end
      check("err_count", err_count, exp_cnt);
      hold_prev <= m_valid && !m_ready;
      prev_idx  <= m_encoded;
      prev_oh   <= m_unencoded;
      prev_err  <= m_error;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  task automatic send(input logic [EW-1:0] idx);
    int n;
    bit acc;
    s_valid   = 1'b1;
    s_encoded = idx;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  initial begin
    int start, cyc, outs0;
    bit acc;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_encoded = '0;
    m_ready   = 1'b0;
    #3;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_unencoded", m_unencoded, 0);
    check("rst_m_encoded", m_encoded, 0);
    check("rst_m_error", m_error, 0);
    check("rst_err_count", err_count, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_after_reset", s_ready, 1);

    // Back-to-back stream, no backpressure.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(EW'(i));
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: first beat held in out, second parks in skid.
    m_ready = 1'b0;
    send(EW'(2));
    send(EW'(1));
    check("bp_s_ready_low", s_ready, 0);
    check("bp_held_onehot", m_unencoded, 5'b00100);
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_s_ready_back", s_ready, 1);

    // Out-of-range beats drive the error counter into saturation.
    for (int i = 0; i < 300; i++) send(EW'(6));
    send(EW'(7));
    repeat (3) @(posedge clk);
    #1;
`ifdef ONEHOT_DECODER_RANGE_CHECK_EN
    check("err_count_saturated", err_count, 255);
`else
    check("err_count_tied", err_count, 0);
`endif

    // Asynchronous reset with both stages full.
    m_ready = 1'b0;
    send(EW'(1));
    send(EW'(4));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_m_unencoded", m_unencoded, 0);
    check("midrst_m_encoded", m_encoded, 0);
    check("midrst_err_count", err_count, 0);
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    outs0 = beats_out;
    send(EW'(3));
    repeat (4) @(posedge clk);
    #1;
    check("midrst_single_beat", beats_out - outs0, 1);

    // Random stress.
    start = beats_in;
    cyc   = 0;
    while (beats_in < start + 10000 && cyc < 60000) begin
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      cyc++;
      m_ready = ($urandom_range(0, 99) < 70);
      if (!s_valid || acc) begin
        s_valid   = ($urandom_range(0, 99) < 70);
        s_encoded = EW'($urandom_range(0, 7));
      end
    end
    s_valid = 1'b0;
    check("stress_beats_done", beats_in >= start + 10000, 1);
    m_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_empty", q.size(), 0);
    check("in_out_balance", beats_in - beats_out, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
